// File: rtl/sample_ram_arbiter.sv
`default_nettype none
// sample_ram_arbiter: shares one sample-RAM port between a ring-buffer writer and a random-access reader.
// Round-robin arbitration, registered RAM command, pipelined read return. Rev 1.0
module sample_ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cap_en,
  input  logic              cap_clear,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  output logic              smp_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   fill_cnt,
  output logic              wrapped,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [ADDR_W-1:0] c_PTR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   c_FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic w_wreq;
  logic w_rreq;
  logic w_wwin;
  logic w_rwin;

  logic              prio_q;  // 0: writer favoured, 1: reader favoured
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_d;
  logic [ADDR_W:0]   fill_q;
  logic [ADDR_W:0]   fill_d;
  logic              wrapped_q;
  logic              wrapped_d;

  logic              clken_q;
  logic              cs_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic [RD_LAT:0]   vld_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  // Grants are gated by reset so no combinational grant leaks out while held in reset.
  assign w_wreq = reset_reset_n & smp_valid & cap_en & ~cap_clear;
  assign w_rreq = reset_reset_n & rd_req;
  assign w_wwin = w_wreq & (~w_rreq | ~prio_q);
  assign w_rwin = w_rreq & (~w_wreq | prio_q);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    wrapped_d = wrapped_q;
    if (cap_clear) begin
      wr_ptr_d  = '0;
      fill_d    = '0;
      wrapped_d = 1'b0;
    end else if (w_wwin) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != c_FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
      if (wr_ptr_q == c_PTR_MAX) begin
        wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prio_q    <= 1'b0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      wrapped_q <= wrapped_d;
      if (w_wwin | w_rwin) begin
        prio_q <= w_wwin;
      end
    end
  end

  // Memory command is registered; address/data hold when idle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      clken_q <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      clken_q <= 1'b1;
      cs_q    <= w_wwin | w_rwin;
      we_q    <= w_wwin;
      if (w_wwin) begin
        addr_q  <= wr_ptr_q;
        wdata_q <= smp_data;
        be_q    <= '1;
      end else if (w_rwin) begin
        addr_q <= rd_addr;
        be_q   <= '1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vld_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      vld_q      <= {vld_q[RD_LAT-1:0], w_rwin};
      rd_valid_q <= vld_q[RD_LAT];
      if (vld_q[RD_LAT]) begin
        rd_data_q <= mem_readdata;
      end
    end
  end

  assign smp_ready      = w_wwin;
  assign rd_gnt         = w_rwin;
  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign wr_ptr         = wr_ptr_q;
  assign fill_cnt       = fill_q;
  assign wrapped        = wrapped_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_clken      = clken_q;
  assign mem_write      = we_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_ram_arbiter.sv
`default_nettype none
// tb_sample_ram_arbiter: directed table plus hand sequences for sample_ram_arbiter.
// Rev 1.0
module tb_sample_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cap_en;
  logic        cap_clear;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        smp_ready;
  logic        rd_req;
  logic [8:0]  rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [8:0]  wr_ptr;
  logic [9:0]  fill_cnt;
  logic        wrapped;
  logic [8:0]  mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_readdata;

  int total;
  int bad;

  sample_ram_arbiter dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .cap_en         (cap_en),
    .cap_clear      (cap_clear),
    .smp_valid      (smp_valid),
    .smp_data       (smp_data),
    .smp_ready      (smp_ready),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_gnt         (rd_gnt),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .wr_ptr         (wr_ptr),
    .fill_cnt       (fill_cnt),
    .wrapped        (wrapped),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // On-chip RAM s2 port, one cycle read latency.
  logic [15:0] ram [0:511];
  logic [15:0] ram_q;
  assign mem_readdata = ram_q;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
        if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  typedef struct packed {
    logic        sv;
    logic        ce;
    logic        rq;
    logic [8:0]  ra;
    logic [15:0] sd;
    logic        e_rdy;
    logic        e_gnt;
    logic        e_cs;
    logic        e_we;
    logic [8:0]  e_addr;
    logic [15:0] e_wd;
    logic [8:0]  e_ptr;
    logic        e_rv;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    smp_valid = 1'b0;
    cap_en    = 1'b1;
    cap_clear = 1'b0;
    rd_req    = 1'b0;
  endtask

  task automatic do_reset();
    next_cyc();
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
  endtask

  task automatic do_read(input logic [8:0] a, input logic [15:0] exp);
    rd_req  = 1'b1;
    rd_addr = a;
    @(negedge clk);
    chk("rd_gnt", 32'(rd_gnt), 32'd1);
    next_cyc();
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_valid_early1", 32'(rd_valid), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("rd_valid_early2", 32'(rd_valid), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_data", 32'(rd_data), 32'(exp));
    next_cyc();
  endtask

  initial begin
    int   wcnt;
    int   vcnt;
    logic rdy_bad;
    logic seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    smp_valid = 1'b0;
    cap_en    = 1'b0;
    cap_clear = 1'b0;
    rd_req    = 1'b0;
    rd_addr   = '0;
    smp_data  = '0;
    ram_q     = '0;
    for (int i = 0; i < 512; i++) ram[i] = '0;

    //                sv ce rq ra      sd        rdy gnt cs we addr  wd        ptr rv rd
    vecs[0]  = '{1'b1,1'b1,1'b0,9'd0,16'h1111, 1'b1,1'b0,1'b0,1'b0,9'd0,16'h0000, 9'd0,1'b0,16'h0000};
    vecs[1]  = '{1'b1,1'b1,1'b0,9'd0,16'h2222, 1'b1,1'b0,1'b1,1'b1,9'd0,16'h1111, 9'd1,1'b0,16'h0000};
    vecs[2]  = '{1'b1,1'b1,1'b0,9'd0,16'h3333, 1'b1,1'b0,1'b1,1'b1,9'd1,16'h2222, 9'd2,1'b0,16'h0000};
    vecs[3]  = '{1'b1,1'b1,1'b0,9'd0,16'h4444, 1'b1,1'b0,1'b1,1'b1,9'd2,16'h3333, 9'd3,1'b0,16'h0000};
    vecs[4]  = '{1'b0,1'b1,1'b0,9'd0,16'h0000, 1'b0,1'b0,1'b1,1'b1,9'd3,16'h4444, 9'd4,1'b0,16'h0000};
    vecs[5]  = '{1'b1,1'b0,1'b0,9'd0,16'h5555, 1'b0,1'b0,1'b0,1'b0,9'd3,16'h4444, 9'd4,1'b0,16'h0000};
    vecs[6]  = '{1'b0,1'b1,1'b1,9'd2,16'h0000, 1'b0,1'b1,1'b0,1'b0,9'd3,16'h4444, 9'd4,1'b0,16'h0000};
    vecs[7]  = '{1'b0,1'b1,1'b0,9'd0,16'h0000, 1'b0,1'b0,1'b1,1'b0,9'd2,16'h4444, 9'd4,1'b0,16'h0000};
    vecs[8]  = '{1'b0,1'b1,1'b0,9'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,9'd2,16'h4444, 9'd4,1'b0,16'h0000};
    vecs[9]  = '{1'b0,1'b1,1'b0,9'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,9'd2,16'h4444, 9'd4,1'b1,16'h3333};
    vecs[10] = '{1'b0,1'b1,1'b0,9'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0,9'd2,16'h4444, 9'd4,1'b0,16'h0000};

    // Reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      smp_valid = 1'($urandom);
      cap_en    = 1'($urandom);
      cap_clear = 1'($urandom);
      rd_req    = 1'($urandom);
      rd_addr   = 9'($urandom);
      smp_data  = 16'($urandom);
      @(negedge clk);
      chk("rst_ctl", 32'({smp_ready, rd_gnt, rd_valid, wrapped, mem_chipselect,
                          mem_clken, mem_write, mem_byteenable}), 32'd0);
      chk("rst_data", 32'(rd_data | mem_writedata), 32'd0);
      chk("rst_addr", 32'({wr_ptr | mem_address, fill_cnt}), 32'd0);
    end
    next_cyc();
    idle_in();
    rst_n = 1'b1;
    @(negedge clk);
    chk("clken_before_edge", 32'(mem_clken), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("clken_after_edge", 32'(mem_clken), 32'd1);
    chk("ptr_after_reset", 32'(wr_ptr), 32'd0);
    chk("fill_after_reset", 32'(fill_cnt), 32'd0);
    next_cyc();

    // Table: writer-only, blocked writer, single read
    for (int i = 0; i < 11; i++) begin
      smp_valid = vecs[i].sv;
      cap_en    = vecs[i].ce;
      cap_clear = 1'b0;
      rd_req    = vecs[i].rq;
      rd_addr   = vecs[i].ra;
      smp_data  = vecs[i].sd;
      @(negedge clk);
      chk("v_ready", 32'(smp_ready), 32'(vecs[i].e_rdy));
      chk("v_gnt", 32'(rd_gnt), 32'(vecs[i].e_gnt));
      chk("v_cs", 32'(mem_chipselect), 32'(vecs[i].e_cs));
      chk("v_we", 32'(mem_write), 32'(vecs[i].e_we));
      chk("v_addr", 32'(mem_address), 32'(vecs[i].e_addr));
      chk("v_wdata", 32'(mem_writedata), 32'(vecs[i].e_wd));
      chk("v_ptr", 32'(wr_ptr), 32'(vecs[i].e_ptr));
      chk("v_fill", 32'(fill_cnt), 32'(vecs[i].e_ptr));
      chk("v_wrapped", 32'(wrapped), 32'd0);
      chk("v_rvalid", 32'(rd_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk("v_rdata", 32'(rd_data), 32'(vecs[i].e_rd));
      next_cyc();
    end

    // Back-to-back reads of 0,1,2
    for (int k = 0; k < 3; k++) begin
      rd_req  = 1'b1;
      rd_addr = 9'(k);
      @(negedge clk);
      chk("b2b_gnt", 32'(rd_gnt), 32'd1);
      next_cyc();
    end
    rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_rvalid", 32'(rd_valid), (k < 3) ? 32'd1 : 32'd0);
      if (k == 0) chk("b2b_data0", 32'(rd_data), 32'h1111);
      if (k == 1) chk("b2b_data1", 32'(rd_data), 32'h2222);
      if (k == 2) chk("b2b_data2", 32'(rd_data), 32'h3333);
      next_cyc();
    end

    // Contention from reset: W,R,W,R,W,R
    do_reset();
    wcnt = 0;
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 6) begin
        smp_valid = 1'b1;
        cap_en    = 1'b1;
        rd_req    = 1'b1;
        rd_addr   = 9'(k);
        smp_data  = 16'hA000 + 16'(k);
      end else begin
        idle_in();
      end
      @(negedge clk);
      if (k < 6) begin
        chk("cont_ready", 32'(smp_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("cont_gnt", 32'(rd_gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
      end
      chk("cont_excl", 32'(smp_ready & rd_gnt), 32'd0);
      if (mem_chipselect && mem_write) wcnt++;
      if (rd_valid) vcnt++;
      next_cyc();
    end
    chk("cont_writes", 32'(wcnt), 32'd3);
    chk("cont_rvalids", 32'(vcnt), 32'd3);
    chk("cont_ptr", 32'(wr_ptr), 32'd3);

    // Wrap: 513 samples valued 1..513
    do_reset();
    rdy_bad = 1'b0;
    for (int i = 1; i <= 513; i++) begin
      smp_valid = 1'b1;
      cap_en    = 1'b1;
      smp_data  = 16'(i);
      @(negedge clk);
      if (smp_ready !== 1'b1) rdy_bad = 1'b1;
      if (i == 512) begin
        chk("pre_wrap_ptr", 32'(wr_ptr), 32'd511);
        chk("pre_wrap_fill", 32'(fill_cnt), 32'd511);
        chk("pre_wrap_flag", 32'(wrapped), 32'd0);
      end
      if (i == 513) begin
        chk("wrap_ptr", 32'(wr_ptr), 32'd0);
        chk("wrap_fill", 32'(fill_cnt), 32'd512);
        chk("wrap_flag", 32'(wrapped), 32'd1);
      end
      next_cyc();
    end
    idle_in();
    @(negedge clk);
    chk("stream_ready", 32'(rdy_bad), 32'd0);
    chk("post_wrap_ptr", 32'(wr_ptr), 32'd1);
    chk("post_wrap_fill", 32'(fill_cnt), 32'd512);
    chk("post_wrap_flag", 32'(wrapped), 32'd1);
    next_cyc();
    do_read(9'd0, 16'd513);

    // cap_clear at wr_ptr=10 with a concurrent read
    for (int k = 0; k < 9; k++) begin
      smp_valid = 1'b1;
      smp_data  = 16'hC000 + 16'(k);
      next_cyc();
    end
    cap_clear = 1'b1;
    rd_req    = 1'b1;
    rd_addr   = 9'd5;
    @(negedge clk);
    chk("clr_ready", 32'(smp_ready), 32'd0);
    chk("clr_gnt", 32'(rd_gnt), 32'd1);
    chk("clr_ptr_before", 32'(wr_ptr), 32'd10);
    chk("clr_last_write", 32'({mem_chipselect, mem_write, mem_address}), 32'({2'b11, 9'd9}));
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("clr_ptr", 32'(wr_ptr), 32'd0);
    chk("clr_fill", 32'(fill_cnt), 32'd0);
    chk("clr_wrapped", 32'(wrapped), 32'd0);
    chk("clr_read_cmd", 32'({mem_chipselect, mem_write, mem_address}), 32'({2'b10, 9'd5}));
    repeat (4) next_cyc();

    // Reset one cycle after a read grant flushes the read
    rd_req  = 1'b1;
    rd_addr = 9'd0;
    @(negedge clk);
    chk("flush_gnt", 32'(rd_gnt), 32'd1);
    next_cyc();
    rst_n  = 1'b0;
    rd_req = 1'b0;
    seen   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_valid) seen = 1'b1;
      next_cyc();
      if (k == 2) rst_n = 1'b1;
    end
    chk("flush_no_rvalid", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_ram_arbiter.md
Name: sample_ram_arbiter

Overview:
- Fabric-side controller that shares the 16-bit on-chip sample RAM slave port (s2: 9-bit address, 2-bit byteenable, chipselect/clken/write) between two requesters.
- Requester 1 is the multimeter ADC sample stream, written into a ring buffer with an auto-incrementing pointer.
- Requester 2 is a random-access reader (display or measurement logic).
- One RAM access per cycle, round-robin under contention, pipelined reads, and capture status (pointer, fill, wrap).

Parameters:
- ADDR_W, 9, RAM word-address width; ring depth = 2^ADDR_W.
- DATA_W, 16, sample/RAM data width.
- BE_W, 2, byteenable width (DATA_W/8).
- RD_LAT, 1, RAM read latency in cycles after address sampled; legal values 1, 2.

Ports:
- clk_clk  in  1  single clock for all logic.
- reset_reset_n  in  1  asynchronous active-low reset.
- cap_en  in  1  capture enable; 0 blocks the writer.
- cap_clear  in  1  one-cycle pulse: clear pointer and status.
- smp_valid  in  1  writer has a sample.
- smp_data  in  DATA_W  sample value.
- smp_ready  out  1  writer accepted this cycle (combinational).
- rd_req  in  1  reader request; held until rd_gnt.
- rd_addr  in  ADDR_W  read address; held with rd_req.
- rd_gnt  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  read data valid, one cycle per granted read.
- rd_data  out  DATA_W  read data.
- wr_ptr  out  ADDR_W  next write address.
- fill_cnt  out  ADDR_W+1  samples stored, saturating at 2^ADDR_W.
- wrapped  out  1  ring has wrapped at least once since clear.
- mem_address  out  ADDR_W  to RAM s2.
- mem_chipselect  out  1  to RAM s2.
- mem_clken  out  1  to RAM s2.
- mem_write  out  1  to RAM s2.
- mem_writedata  out  DATA_W  to RAM s2.
- mem_byteenable  out  BE_W  to RAM s2.
- mem_readdata  in  DATA_W  from RAM s2.

Behaviour:

Reset:
- Async assert of reset_reset_n clears all registers.
- All outputs are 0 during reset, including mem_clken and prio. prio = writer.
- The rd_valid pipeline is flushed, so no rd_valid is produced for reads granted before reset.
- mem_clken goes to 1 on the first clock edge after deassert and stays 1.

Requests and arbitration:
- w_req = smp_valid & cap_en & ~cap_clear.
- r_req = rd_req.
- Only one requesting: it wins.
- Both requesting: the winner is the side selected by prio.
- After any grant, prio points to the other side.
- smp_ready = writer wins; rd_gnt = reader wins.

Registered memory command:
- The grant at clock edge E loads the mem_* registers, which drive the RAM during the next cycle.
- Write: mem_chipselect=1, mem_write=1, mem_address=wr_ptr, mem_writedata=smp_data, mem_byteenable all ones.
- Read: mem_chipselect=1, mem_write=0, mem_address=rd_addr, mem_byteenable all ones.
- No grant: mem_chipselect=0, mem_write=0; address and data hold.

Read pipeline:
- Valid shift register of depth RD_LAT+1.
- rd_data is registered from mem_readdata.
- A read granted in cycle N gives rd_valid=1 in cycle N+RD_LAT+2 (3 for the default).
- Back-to-back grants give back-to-back rd_valid, in order.

Write side:
- On each accepted write, wr_ptr increments modulo 2^ADDR_W.
- fill_cnt increments, saturating at 2^ADDR_W.
- wrapped is set when wr_ptr goes from 2^ADDR_W-1 to 0, and stays sticky.

cap_clear:
- Sets wr_ptr=0, fill_cnt=0, wrapped=0 at the next edge.
- smp_ready=0 in that cycle; the reader may still be granted.
- A write already registered into mem_* completes unchanged.

Reads of unwritten locations return RAM contents; no protection.

Test Plan:
1. Reset: hold reset_reset_n=0 with random inputs -> all outputs 0; mem_clken=1 one edge after release; wr_ptr=0, fill_cnt=0.
2. Writer only: cap_en=1, smp_data 0x1111,0x2222,0x3333,0x4444 on consecutive cycles -> smp_ready=1 each cycle; mem_write=1 with address 0..3 one cycle later; then wr_ptr=4, fill_cnt=4, wrapped=0.
3. Reader: rd_req addr 2 alone (after test 2) -> rd_gnt same cycle, rd_valid 3 cycles later with rd_data=0x3333. Then reads of 0,1,2 back-to-back -> rd_valid 3 consecutive cycles with 0x1111, 0x2222, 0x3333.
4. Contention: smp_valid=1 and rd_req=1 held 6 cycles from reset -> grants W,R,W,R,W,R; smp_ready and rd_gnt never both 1; 3 writes and 3 rd_valid.
5. Wrap: stream 513 samples of value i (i=1..513) -> wr_ptr=1, fill_cnt=512, wrapped=1; read addr 0 -> 513.
6. cap_clear mid-stream at wr_ptr=10 -> smp_ready=0 that cycle, then wr_ptr=0, fill_cnt=0, wrapped=0. Assert reset one cycle after a read grant -> no rd_valid ever appears for that read.
